// File: rtl/uart_pkg.sv
// Shared definitions for the UART DRAM streamer and its byte transmitter.
// CSUM state exists only when UART_DRAM_STREAMER_CHECKSUM_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4,
        DONE  = 3'd5
`ifdef UART_DRAM_STREAMER_CHECKSUM_EN
        , CSUM = 3'd6
`endif
    } state_e;

    localparam logic        UART_IDLE_LVL  = 1'b1;
    localparam logic        UART_START_LVL = 1'b0;
    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned DRAM_READ_WAIT = 2;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: load/ready handshake, START/DATA/STOP bit timing, registered Tx.
// Independent of UART_DRAM_STREAMER_CHECKSUM_EN.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       byte_done,
    output state_e     phase,
    output logic       tx
);

    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

    state_e            phase_q, phase_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              bit_end;

    assign bit_end   = (baud_q == BAUD_LAST);
    assign byte_done = (phase_q == STOP) && bit_end;
    // Ready during the last stop cycle lets the next byte start back-to-back.
    assign ready     = (phase_q == IDLE) || byte_done;
    assign phase     = phase_q;
    assign tx        = tx_q;

    always_comb begin
        phase_d = phase_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;

        if (phase_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (phase_q)
            START: begin
                if (bit_end) begin
                    phase_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        phase_d = STOP;
                        tx_d    = UART_IDLE_LVL;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    phase_d = IDLE;
                end
            end
            default: ;
        endcase

        if (load && ready) begin
            phase_d = START;
            baud_d  = '0;
            shift_d = data;
            tx_d    = UART_START_LVL;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            phase_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= UART_IDLE_LVL;
        end else begin
            phase_q <= phase_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/uart_dram_streamer.sv
// Streams BYTE_COUNT bytes from DRAM (starting at BASE_ADDR) out over 8N1 UART.
// UART_DRAM_STREAMER_CHECKSUM_EN appends a mod-256 sum byte after the data bytes.
module uart_dram_streamer
    import uart_pkg::*;
#(
    parameter int unsigned       CLKS_PER_BIT = 5208,
    parameter int unsigned       ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int unsigned       BYTE_COUNT   = 16384
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start_Tx,
    input  logic [7:0]        data_in,
    output logic [ADDR_W-1:0] D_address,
    output logic              Tx,
    output logic              busy,
    output logic              Tx_done
);

    localparam int unsigned      CNT_W      = $clog2(BYTE_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BYTE_COUNT - 1);
    localparam logic             FETCH_LAST = 1'(DRAM_READ_WAIT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fetch_q, fetch_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef UART_DRAM_STREAMER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic       start_edge;
    logic       tx_load;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_byte_done;
    state_e     tx_phase;

    assign start_edge = start_Tx & ~start_q;
    assign D_address  = addr_q;
    assign busy       = busy_q;
    assign Tx_done    = done_q;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk       (clk),
        .clear_n   (clear_n),
        .load      (tx_load),
        .data      (tx_data),
        .ready     (tx_ready),
        .byte_done (tx_byte_done),
        .phase     (tx_phase),
        .tx        (Tx)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        fetch_d = fetch_q;
        start_d = start_Tx;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef UART_DRAM_STREAMER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        tx_load = 1'b0;
        tx_data = data_in;

        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_d = FETCH;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    addr_d  = BASE_ADDR;
                    cnt_d   = '0;
                    fetch_d = '0;
`ifdef UART_DRAM_STREAMER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            FETCH: begin
                if (fetch_q == FETCH_LAST) begin
                    if (tx_ready) begin
                        tx_load = 1'b1;
                        state_d = START;
`ifdef UART_DRAM_STREAMER_CHECKSUM_EN
                        sum_d   = sum_q + data_in;
`endif
                    end
                end else begin
                    fetch_d = fetch_q + 1'b1;
                end
            end
            // Bit-level state tracks the serialiser until the stop bit ends.
            START, DATA, STOP: begin
                if (tx_byte_done) begin
                    if (cnt_q == CNT_LAST) begin
`ifdef UART_DRAM_STREAMER_CHECKSUM_EN
                        state_d = CSUM;
                        tx_load = 1'b1;
                        tx_data = sum_q;
`else
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = FETCH;
                        cnt_d   = cnt_q + 1'b1;
                        addr_d  = addr_q + 1'b1;
                        fetch_d = '0;
                    end
                end else begin
                    state_d = tx_phase;
                end
            end
`ifdef UART_DRAM_STREAMER_CHECKSUM_EN
            CSUM: begin
                if (tx_byte_done) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q <= IDLE;
            addr_q  <= BASE_ADDR;
            cnt_q   <= '0;
            fetch_q <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_DRAM_STREAMER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            fetch_q <= fetch_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_DRAM_STREAMER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_dram_streamer.sv
// Scoreboard bench for uart_dram_streamer: two instances (base 0 / base 0xFFFF wrap),
// a registered DRAM model each, and a UART decoder monitor per instance.
`timescale 1ns/1ps
module tb_uart_dram_streamer;

    localparam int unsigned CPB      = 4;
    localparam int unsigned BYTE_LEN = 2 + 10 * CPB;
`ifdef UART_DRAM_STREAMER_CHECKSUM_EN
    localparam int unsigned CSUM_LEN = 10 * CPB;
    localparam bit          HAS_CSUM = 1'b1;
`else
    localparam int unsigned CSUM_LEN = 0;
    localparam bit          HAS_CSUM = 1'b0;
`endif
    localparam logic [15:0] BASE0 = 16'h0000;
    localparam logic [15:0] BASE1 = 16'hFFFF;
    localparam int unsigned BC0   = 3;
    localparam int unsigned BC1   = 2;

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] addr;
    } exp_t;

    exp_t exp_q[$];

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        start_a [2];
    logic        clr_a   [2];
    logic [7:0]  q_a     [2];
    logic [15:0] addr_a  [2];
    logic        tx_a    [2];
    logic        busy_a  [2];
    logic        done_a  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_dram_streamer #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (16),
        .BASE_ADDR    (BASE0),
        .BYTE_COUNT   (BC0)
    ) u_dut0 (
        .clk       (clk),
        .clear_n   (clr_a[0]),
        .start_Tx  (start_a[0]),
        .data_in   (q_a[0]),
        .D_address (addr_a[0]),
        .Tx        (tx_a[0]),
        .busy      (busy_a[0]),
        .Tx_done   (done_a[0])
    );

    uart_dram_streamer #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (16),
        .BASE_ADDR    (BASE1),
        .BYTE_COUNT   (BC1)
    ) u_dut1 (
        .clk       (clk),
        .clear_n   (clr_a[1]),
        .start_Tx  (start_a[1]),
        .data_in   (q_a[1]),
        .D_address (addr_a[1]),
        .Tx        (tx_a[1]),
        .busy      (busy_a[1]),
        .Tx_done   (done_a[1])
    );

    function automatic logic [7:0] dram(input int g, input logic [15:0] a);
        if (g == 0) begin
            case (a)
                16'h0000: return 8'h55;
                16'h0001: return 8'hA3;
                16'h0002: return 8'h00;
                default:  return 8'hEE;
            endcase
        end else begin
            case (a)
                16'hFFFF: return 8'h80;
                16'h0000: return 8'h90;
                default:  return 8'hEE;
            endcase
        end
    endfunction

    always @(posedge clk) begin
        q_a[0] <= dram(0, addr_a[0]);
        q_a[1] <= dram(1, addr_a[1]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Hand-computed frame contents: DUT0 = 55,A3,00 (sum F8); DUT1 = 80,90 (sum 10).
    task automatic push_frame(input int g);
        if (g == 0) begin
            exp_q.push_back('{data: 8'h55, addr: 16'h0000});
            exp_q.push_back('{data: 8'hA3, addr: 16'h0001});
            exp_q.push_back('{data: 8'h00, addr: 16'h0002});
            if (HAS_CSUM) exp_q.push_back('{data: 8'hF8, addr: 16'h0002});
        end else begin
            exp_q.push_back('{data: 8'h80, addr: 16'hFFFF});
            exp_q.push_back('{data: 8'h90, addr: 16'h0000});
            if (HAS_CSUM) exp_q.push_back('{data: 8'h10, addr: 16'h0000});
        end
    endtask

    task automatic start_frame(input int g, output int unsigned t_edge);
        @(negedge clk);
        start_a[g] = 1'b1;
        t_edge = cyc + 1;
        @(negedge clk);
        check("busy_after_start", {31'd0, busy_a[g]}, 32'd1);
        check("done_clear_after_start", {31'd0, done_a[g]}, 32'd0);
    endtask

    task automatic wait_done(input int g, input int unsigned t_edge, input int unsigned len,
                             input string name);
        int unsigned n = 0;
        while (done_a[g] !== 1'b1 && n < len + 50) begin
            @(negedge clk);
            n++;
        end
        check(name, cyc - t_edge, len);
        check("busy_low_at_done", {31'd0, busy_a[g]}, 32'd0);
    endtask

    task automatic check_reset_state(input int g, input logic [15:0] base);
        check("rst_tx", {31'd0, tx_a[g]}, 32'd1);
        check("rst_busy", {31'd0, busy_a[g]}, 32'd0);
        check("rst_done", {31'd0, done_a[g]}, 32'd0);
        check("rst_addr", {16'd0, addr_a[g]}, {16'd0, base});
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        initial begin
            logic [7:0]  b;
            logic [15:0] a;
            logic        stop_bit;
            bit          aborted;
            exp_t        e;
            forever begin
                @(negedge clk);
                if (clr_a[g] === 1'b1 && tx_a[g] === 1'b0) begin
                    a       = addr_a[g];
                    aborted = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        if (clr_a[g] !== 1'b1) aborted = 1'b1;
                        b[i] = tx_a[g];
                    end
                    repeat (CPB) @(negedge clk);
                    if (clr_a[g] !== 1'b1) aborted = 1'b1;
                    stop_bit = tx_a[g];
                    if (!aborted) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_byte: dut%0d got 0x%0h with no byte expected", g, b);
                        end else begin
                            e = exp_q.pop_front();
                            check("rx_data", {24'd0, b}, {24'd0, e.data});
                            check("rx_stop", {31'd0, stop_bit}, 32'd1);
                            check("rx_addr", {16'd0, a}, {16'd0, e.addr});
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        start_a[0] = 1'b0; start_a[1] = 1'b0;
        clr_a[0]   = 1'b0; clr_a[1]   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state(0, BASE0);
        check_reset_state(1, BASE1);
        clr_a[0] = 1'b1; clr_a[1] = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame, start held high through DONE.
        push_frame(0);
        start_frame(0, t);
        wait_done(0, t, BC0 * BYTE_LEN + CSUM_LEN, "frame_len_basic");
        repeat (60) @(negedge clk);
        check("held_start_no_restart_busy", {31'd0, busy_a[0]}, 32'd0);
        check("held_start_done_sticky", {31'd0, done_a[0]}, 32'd1);
        start_a[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("done_sticky_after_fall", {31'd0, done_a[0]}, 32'd1);

        // Restart from DONE.
        push_frame(0);
        start_frame(0, t);
        wait_done(0, t, BC0 * BYTE_LEN + CSUM_LEN, "frame_len_restart");

        // Second start edge mid-DATA of byte 0 is ignored.
        start_a[0] = 1'b0;
        repeat (2) @(negedge clk);
        push_frame(0);
        start_frame(0, t);
        repeat (10) @(negedge clk);
        start_a[0] = 1'b0;
        repeat (5) @(negedge clk);
        start_a[0] = 1'b1;
        wait_done(0, t, BC0 * BYTE_LEN + CSUM_LEN, "frame_len_start_ignored");

        // Reset during bit 4 of byte 1, then a fresh frame.
        start_a[0] = 1'b0;
        repeat (2) @(negedge clk);
        push_frame(0);
        start_frame(0, t);
        repeat (65 - 1) @(negedge clk);
        check("pre_reset_busy", {31'd0, busy_a[0]}, 32'd1);
        clr_a[0]   = 1'b0;
        start_a[0] = 1'b0;
        @(negedge clk);
        check_reset_state(0, BASE0);
        repeat (4) @(negedge clk);
        clr_a[0] = 1'b1;
        repeat (30) @(negedge clk);
        check("after_reset_idle_tx", {31'd0, tx_a[0]}, 32'd1);
        exp_q.delete();
        push_frame(0);
        start_frame(0, t);
        wait_done(0, t, BC0 * BYTE_LEN + CSUM_LEN, "frame_len_after_reset");

        // Address wrap 0xFFFF -> 0x0000.
        push_frame(1);
        start_frame(1, t);
        check("wrap_first_addr", {16'd0, addr_a[1]}, 32'h0000_FFFF);
        wait_done(1, t, BC1 * BYTE_LEN + CSUM_LEN, "frame_len_wrap");
        check("wrap_final_addr", {16'd0, addr_a[1]}, 32'h0000_0000);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
